// File: rtl/packet_history_extractor.sv
// Strips the four 512-bit history beats ahead of each packet, emits their 16 tuples on a side stream,
// and forwards the packet. Optional pad-field error counter under HIST_PAD_CHECK_EN.
module packet_history_extractor #(
  parameter int C_M_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int TUPLE_WIDTH          = 112,
  parameter int CNT_WIDTH            = 16
) (
  input  logic                              axis_aclk,
  input  logic                              axis_reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [TUPLE_WIDTH-1:0]            m_hist_tdata,
  output logic [3:0]                        m_hist_slot,
  output logic [3:0]                        m_hist_head,
  output logic                              m_hist_tlast,
  output logic                              m_hist_tvalid,
  input  logic                              m_hist_tready,
  output logic [CNT_WIDTH-1:0]              trunc_count
`ifdef HIST_PAD_CHECK_EN
  ,
  output logic [CNT_WIDTH-1:0]              pad_err_count
`endif
);

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  state_t                 state_r;
  logic [1:0]             bcnt_r;
  logic [1:0]             dcnt_r;
  logic [1:0]             dcnt_nxt_s;
  logic [TUPLE_WIDTH-1:0] staging_r [4];
  logic [TUPLE_WIDTH-1:0] beat_tuple_s [4];
  logic [TUPLE_WIDTH-1:0] hist_tdata_r;
  logic [3:0]             hist_slot_r;
  logic [3:0]             hist_head_r;
  logic                   hist_tlast_r;
  logic                   hist_tvalid_r;
  logic [CNT_WIDTH-1:0]   trunc_count_r;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

  assign dcnt_nxt_s    = dcnt_r + 2'd1;
  assign m_hist_tdata  = hist_tdata_r;
  assign m_hist_slot   = hist_slot_r;
  assign m_hist_head   = hist_head_r;
  assign m_hist_tlast  = hist_tlast_r;
  assign m_hist_tvalid = hist_tvalid_r;
  assign trunc_count   = trunc_count_r;

  // Slice the four tuples of the current input beat, highest slot index at the lowest bits
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      beat_tuple_s[j] = s_axis_tdata[C_S_AXIS_DATA_WIDTH-1-j*TUPLE_WIDTH -: TUPLE_WIDTH];
    end
  end

  // Zero-latency payload pass-through; header beats are consumed and never forwarded
  always_comb begin
    if (state_r == ST_PAYLOAD) begin
      m_axis_tdata  = s_axis_tdata;
      m_axis_tkeep  = s_axis_tkeep;
      m_axis_tuser  = s_axis_tuser;
      m_axis_tlast  = s_axis_tlast;
      m_axis_tvalid = s_axis_tvalid;
      s_axis_tready = m_axis_tready;
    end else begin
      m_axis_tdata  = {C_M_AXIS_DATA_WIDTH{1'b0}};
      m_axis_tkeep  = {(C_M_AXIS_DATA_WIDTH/8){1'b0}};
      m_axis_tuser  = {C_M_AXIS_TUSER_WIDTH{1'b0}};
      m_axis_tlast  = 1'b0;
      m_axis_tvalid = 1'b0;
      s_axis_tready = (state_r == ST_HDR);
    end
  end

  // Header/drain/payload sequencing with registered history side-stream
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      state_r       <= ST_HDR;
      bcnt_r        <= 2'd0;
      dcnt_r        <= 2'd0;
      for (int j = 0; j < 4; j++) begin
        staging_r[j] <= {TUPLE_WIDTH{1'b0}};
      end
      hist_tdata_r  <= {TUPLE_WIDTH{1'b0}};
      hist_slot_r   <= 4'd0;
      hist_head_r   <= 4'd0;
      hist_tlast_r  <= 1'b0;
      hist_tvalid_r <= 1'b0;
      trunc_count_r <= {CNT_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_HDR: begin
          if (s_axis_tvalid) begin
            if (s_axis_tlast) begin
              // Packet ended inside the header: drop it and restart at beat 0
              trunc_count_r <= sat_inc(trunc_count_r);
              bcnt_r        <= 2'd0;
            end else begin
              for (int j = 0; j < 4; j++) begin
                staging_r[j] <= beat_tuple_s[j];
              end
              if (bcnt_r == 2'd0) begin
                hist_head_r <= s_axis_tdata[63:60];
              end
              dcnt_r        <= 2'd0;
              hist_tvalid_r <= 1'b1;
              hist_tdata_r  <= beat_tuple_s[0];
              hist_slot_r   <= {bcnt_r, 2'd0};
              hist_tlast_r  <= 1'b0;
              state_r       <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (m_hist_tready) begin
            if (dcnt_r == 2'd3) begin
              hist_tvalid_r <= 1'b0;
              hist_tlast_r  <= 1'b0;
              if (bcnt_r == 2'd3) begin
                bcnt_r  <= 2'd0;
                state_r <= ST_PAYLOAD;
              end else begin
                bcnt_r  <= bcnt_r + 2'd1;
                state_r <= ST_HDR;
              end
            end else begin
              dcnt_r       <= dcnt_nxt_s;
              hist_tdata_r <= staging_r[dcnt_nxt_s];
              hist_slot_r  <= {bcnt_r, dcnt_nxt_s};
              hist_tlast_r <= (bcnt_r == 2'd3) && (dcnt_nxt_s == 2'd3);
            end
          end
        end
        ST_PAYLOAD: begin
          if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
            state_r <= ST_HDR;
          end
        end
        default: begin
          state_r <= ST_HDR;
        end
      endcase
    end
  end

`ifdef HIST_PAD_CHECK_EN
  logic                 pad_nz_s;
  logic [CNT_WIDTH-1:0] pad_err_count_r;

  assign pad_nz_s      = (bcnt_r == 2'd0) ? (s_axis_tdata[59:0] != 60'd0)
                                          : (s_axis_tdata[63:0] != 64'd0);
  assign pad_err_count = pad_err_count_r;

  // Count accepted header beats whose pad field is not all zero
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      pad_err_count_r <= {CNT_WIDTH{1'b0}};
    end else if ((state_r == ST_HDR) && s_axis_tvalid && pad_nz_s) begin
      pad_err_count_r <= sat_inc(pad_err_count_r);
    end
  end
`endif

endmodule

// File: tb/tb_packet_history_extractor.sv
// Directed self-checking bench for packet_history_extractor.
module tb_packet_history_extractor;

  logic         axis_aclk = 1'b0;
  logic         axis_reset;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic [111:0] m_hist_tdata;
  logic [3:0]   m_hist_slot;
  logic [3:0]   m_hist_head;
  logic         m_hist_tlast;
  logic         m_hist_tvalid;
  logic         m_hist_tready;
  logic [15:0]  trunc_count;
`ifdef HIST_PAD_CHECK_EN
  logic [15:0]  pad_err_count;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic last_acc;
  logic toggle_en = 1'b0;

  logic [111:0] hq_data[$];
  logic [3:0]   hq_slot[$];
  logic         hq_last[$];
  logic [511:0] pq_data[$];
  logic [63:0]  pq_keep[$];
  logic [127:0] pq_user[$];
  logic         pq_last[$];

  localparam logic [63:0] KEEP_FULL = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 axis_aclk = ~axis_aclk;

  packet_history_extractor dut (
    .axis_aclk(axis_aclk), .axis_reset(axis_reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_hist_tdata(m_hist_tdata), .m_hist_slot(m_hist_slot), .m_hist_head(m_hist_head),
    .m_hist_tlast(m_hist_tlast), .m_hist_tvalid(m_hist_tvalid), .m_hist_tready(m_hist_tready),
    .trunc_count(trunc_count)
`ifdef HIST_PAD_CHECK_EN
    , .pad_err_count(pad_err_count)
`endif
  );

  function automatic logic [511:0] hdr_beat(input int base, input int k, input logic [63:0] low);
    logic [511:0] r;
    r[63:0] = low;
    for (int j = 0; j < 4; j++) r[511-j*112 -: 112] = 112'(base + 4*k + j + 1);
    return r;
  endfunction

  function automatic logic [511:0] pay_data(input int k);
    return {16{32'hC0DE_0000 + 32'(k)}};
  endfunction

  function automatic logic [127:0] pay_user(input int k);
    return {4{32'hBEEF_0000 + 32'(k)}};
  endfunction

  // One clock: observe handshakes mid-cycle, then advance past the edge
  task automatic tick();
    @(negedge axis_aclk);
    last_acc = s_axis_tvalid && s_axis_tready;
    if (!axis_reset && m_hist_tvalid && m_hist_tready) begin
      hq_data.push_back(m_hist_tdata);
      hq_slot.push_back(m_hist_slot);
      hq_last.push_back(m_hist_tlast);
    end
    if (!axis_reset && m_axis_tvalid && m_axis_tready) begin
      pq_data.push_back(m_axis_tdata);
      pq_keep.push_back(m_axis_tkeep);
      pq_user.push_back(m_axis_tuser);
      pq_last.push_back(m_axis_tlast);
    end
    @(posedge axis_aclk);
    #1;
    cyc++;
    if (toggle_en) m_axis_tready = !m_axis_tready;
  endtask

  task automatic send_beat(input logic [511:0] d, input logic [63:0] k,
                           input logic [127:0] u, input logic l);
    int n;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    last_acc = 1'b0;
    n = 0;
    while (!last_acc && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (!last_acc) begin
      errors++;
      $display("FAIL send_beat_timeout: beat not accepted within %0d cycles", n);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_header(input int base, input logic [3:0] head);
    for (int k = 0; k < 4; k++)
      send_beat(hdr_beat(base, k, (k == 0) ? {head, 60'd0} : 64'd0), KEEP_FULL, 128'h5A, 1'b0);
  endtask

  task automatic send_payload(input int base, input int n, input logic [63:0] last_keep);
    for (int k = 0; k < n; k++)
      send_beat(pay_data(base + k), (k == n - 1) ? last_keep : KEEP_FULL,
                pay_user(base + k), k == n - 1);
  endtask

  task automatic clear_q();
    hq_data.delete(); hq_slot.delete(); hq_last.delete();
    pq_data.delete(); pq_keep.delete(); pq_user.delete(); pq_last.delete();
  endtask

  task automatic test_reset();
    axis_reset = 1'b1;
    repeat (3) @(posedge axis_aclk);
    #1;
    checks++;
    if ({m_hist_tvalid, m_hist_tlast, m_axis_tvalid, m_axis_tlast} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_valids: got %b want 0000", {m_hist_tvalid, m_hist_tlast, m_axis_tvalid, m_axis_tlast});
    end
    checks++;
    if ({m_hist_tdata, m_hist_slot, m_hist_head, trunc_count} !== 136'd0) begin
      errors++;
      $display("FAIL reset_regs: data %h slot %h head %h trunc %0d want 0", m_hist_tdata, m_hist_slot, m_hist_head, trunc_count);
    end
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_tready: got %b want 1", s_axis_tready);
    end
    axis_reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int c0;
    clear_q();
    c0 = cyc;
    send_header(0, 4'h9);
    send_payload(0, 3, KEEP_FULL);
    checks++;
    if (cyc - c0 !== 23) begin
      errors++;
      $display("FAIL basic_cycles: got %0d want 23", cyc - c0);
    end
    checks++;
    if (hq_data.size() !== 16) begin
      errors++;
      $display("FAIL basic_hist_count: got %0d want 16", hq_data.size());
    end
    for (int i = 0; i < 16 && i < hq_data.size(); i++) begin
      checks++;
      if (hq_data[i] !== 112'(i + 1) || hq_slot[i] !== 4'(i) || hq_last[i] !== (i == 15)) begin
        errors++;
        $display("FAIL basic_hist[%0d]: data %h slot %0d last %b want data %h slot %0d last %b",
                 i, hq_data[i], hq_slot[i], hq_last[i], 112'(i + 1), i, i == 15);
      end
    end
    checks++;
    if (m_hist_head !== 4'h9) begin
      errors++;
      $display("FAIL basic_head: got %h want 9", m_hist_head);
    end
    checks++;
    if (pq_data.size() !== 3) begin
      errors++;
      $display("FAIL basic_pay_count: got %0d want 3", pq_data.size());
    end
    for (int k = 0; k < 3 && k < pq_data.size(); k++) begin
      checks++;
      if (pq_data[k] !== pay_data(k) || pq_keep[k] !== KEEP_FULL || pq_user[k] !== pay_user(k) || pq_last[k] !== (k == 2)) begin
        errors++;
        $display("FAIL basic_pay[%0d]: data %h user %h last %b want data %h user %h last %b",
                 k, pq_data[k][31:0], pq_user[k][31:0], pq_last[k], pay_data(k) & 512'hFFFF_FFFF, pay_user(k) & 128'hFFFF_FFFF, k == 2);
      end
    end
  endtask

  task automatic test_hist_backpressure();
    clear_q();
    send_beat(hdr_beat(0, 0, {4'h9, 60'd0}), KEEP_FULL, 128'h0, 1'b0);
    send_beat(hdr_beat(0, 1, 64'd0), KEEP_FULL, 128'h0, 1'b0);
    m_hist_tready = 1'b0;
    s_axis_tdata  = hdr_beat(0, 2, 64'd0);
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (m_hist_tvalid !== 1'b1 || m_hist_slot !== 4'd4 || m_hist_tdata !== 112'd5 || s_axis_tready !== 1'b0) begin
        errors++;
        $display("FAIL stall_frozen[%0d]: valid %b slot %0d data %h s_tready %b want 1 4 5 0",
                 c, m_hist_tvalid, m_hist_slot, m_hist_tdata, s_axis_tready);
      end
    end
    m_hist_tready = 1'b1;
    send_beat(hdr_beat(0, 2, 64'd0), KEEP_FULL, 128'h0, 1'b0);
    send_beat(hdr_beat(0, 3, 64'd0), KEEP_FULL, 128'h0, 1'b0);
    send_payload(0, 1, KEEP_FULL);
    checks++;
    if (hq_data.size() !== 16) begin
      errors++;
      $display("FAIL stall_hist_count: got %0d want 16", hq_data.size());
    end
    for (int i = 0; i < 16 && i < hq_data.size(); i++) begin
      checks++;
      if (hq_slot[i] !== 4'(i) || hq_data[i] !== 112'(i + 1)) begin
        errors++;
        $display("FAIL stall_hist[%0d]: slot %0d data %h want slot %0d data %h", i, hq_slot[i], hq_data[i], i, 112'(i + 1));
      end
    end
  endtask

  task automatic test_payload_backpressure();
    clear_q();
    send_header(0, 4'h1);
    toggle_en = 1'b1;
    send_payload(40, 5, 64'h0000_00FF_FFFF_FFFF);
    toggle_en = 1'b0;
    m_axis_tready = 1'b1;
    checks++;
    if (pq_data.size() !== 5) begin
      errors++;
      $display("FAIL pay_bp_count: got %0d want 5", pq_data.size());
    end
    for (int k = 0; k < 5 && k < pq_data.size(); k++) begin
      checks++;
      if (pq_data[k] !== pay_data(40 + k) || pq_user[k] !== pay_user(40 + k) || pq_last[k] !== (k == 4) ||
          pq_keep[k] !== ((k == 4) ? 64'h0000_00FF_FFFF_FFFF : KEEP_FULL)) begin
        errors++;
        $display("FAIL pay_bp[%0d]: keep %h last %b data %h want keep %h last %b data %h", k, pq_keep[k], pq_last[k],
                 pq_data[k][31:0], (k == 4) ? 64'h0000_00FF_FFFF_FFFF : KEEP_FULL, k == 4, 32'hC0DE_0000 + 32'(40 + k));
      end
    end
  endtask

  task automatic test_truncation();
    clear_q();
    send_beat(hdr_beat(0, 0, {4'h7, 60'd0}), KEEP_FULL, 128'h0, 1'b0);
    send_beat(hdr_beat(0, 1, 64'd0), KEEP_FULL, 128'h0, 1'b0);
    send_beat(hdr_beat(0, 2, 64'd0), KEEP_FULL, 128'h0, 1'b1);
    repeat (3) tick();
    checks++;
    if (hq_data.size() !== 8) begin
      errors++;
      $display("FAIL trunc_hist_count: got %0d want 8", hq_data.size());
    end
    checks++;
    if (trunc_count !== 16'd1) begin
      errors++;
      $display("FAIL trunc_count: got %0d want 1", trunc_count);
    end
    send_header(256, 4'h3);
    send_payload(60, 1, KEEP_FULL);
    checks++;
    if (hq_data.size() !== 24) begin
      errors++;
      $display("FAIL trunc_fresh_count: got %0d want 24", hq_data.size());
    end
    for (int i = 0; i < 16 && 8 + i < hq_data.size(); i++) begin
      checks++;
      if (hq_slot[8 + i] !== 4'(i) || hq_data[8 + i] !== 112'(256 + i + 1)) begin
        errors++;
        $display("FAIL trunc_fresh[%0d]: slot %0d data %h want slot %0d data %h", i, hq_slot[8 + i], hq_data[8 + i], i, 112'(256 + i + 1));
      end
    end
    checks++;
    if (m_hist_head !== 4'h3) begin
      errors++;
      $display("FAIL trunc_head: got %h want 3", m_hist_head);
    end
  endtask

  task automatic test_reset_mid_drain();
    send_beat(hdr_beat(0, 0, {4'hC, 60'd0}), KEEP_FULL, 128'h0, 1'b0);
    send_beat(hdr_beat(0, 1, 64'd0), KEEP_FULL, 128'h0, 1'b0);
    send_beat(hdr_beat(0, 2, 64'd0), KEEP_FULL, 128'h0, 1'b0);
    send_beat(hdr_beat(0, 3, 64'd0), KEEP_FULL, 128'h0, 1'b0);
    tick();
    checks++;
    if (m_hist_tvalid !== 1'b1 || m_hist_slot !== 4'd13) begin
      errors++;
      $display("FAIL rst_pre: valid %b slot %0d want 1 13", m_hist_tvalid, m_hist_slot);
    end
    #2 axis_reset = 1'b1;
    #1;
    checks++;
    if (m_hist_tvalid !== 1'b0 || m_hist_tlast !== 1'b0 || m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL rst_async: hvalid %b hlast %b mvalid %b s_tready %b want 0 0 0 1",
               m_hist_tvalid, m_hist_tlast, m_axis_tvalid, s_axis_tready);
    end
    checks++;
    if (m_hist_slot !== 4'd0 || m_hist_head !== 4'd0 || trunc_count !== 16'd0) begin
      errors++;
      $display("FAIL rst_regs: slot %0d head %h trunc %0d want 0 0 0", m_hist_slot, m_hist_head, trunc_count);
    end
    @(negedge axis_aclk);
    axis_reset = 1'b0;
    @(posedge axis_aclk);
    #1;
    clear_q();
    send_header(512, 4'h5);
    send_payload(80, 2, KEEP_FULL);
    checks++;
    if (hq_data.size() !== 16 || pq_data.size() !== 2) begin
      errors++;
      $display("FAIL rst_after_counts: hist %0d pay %0d want 16 2", hq_data.size(), pq_data.size());
    end
    for (int i = 0; i < 16 && i < hq_data.size(); i++) begin
      checks++;
      if (hq_slot[i] !== 4'(i) || hq_data[i] !== 112'(512 + i + 1) || hq_last[i] !== (i == 15)) begin
        errors++;
        $display("FAIL rst_after_hist[%0d]: slot %0d data %h last %b want slot %0d data %h", i, hq_slot[i], hq_data[i], hq_last[i], i, 112'(512 + i + 1));
      end
    end
    checks++;
    if (m_hist_head !== 4'h5) begin
      errors++;
      $display("FAIL rst_after_head: got %h want 5", m_hist_head);
    end
  endtask

`ifdef HIST_PAD_CHECK_EN
  task automatic test_pad_check();
    clear_q();
    send_beat(hdr_beat(0, 0, {4'h9, 60'h1}), KEEP_FULL, 128'h0, 1'b0);
    send_beat(hdr_beat(0, 1, 64'd0), KEEP_FULL, 128'h0, 1'b0);
    send_beat(hdr_beat(0, 2, 64'h8000_0000_0000_0000), KEEP_FULL, 128'h0, 1'b0);
    send_beat(hdr_beat(0, 3, 64'd0), KEEP_FULL, 128'h0, 1'b0);
    send_payload(90, 1, KEEP_FULL);
    checks++;
    if (pad_err_count !== 16'd2) begin
      errors++;
      $display("FAIL pad_err_count: got %0d want 2", pad_err_count);
    end
    checks++;
    if (hq_data.size() !== 16) begin
      errors++;
      $display("FAIL pad_hist_count: got %0d want 16", hq_data.size());
    end
  endtask
`endif

  initial begin
    axis_reset    = 1'b1;
    s_axis_tdata  = 512'd0;
    s_axis_tkeep  = 64'd0;
    s_axis_tuser  = 128'd0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    m_hist_tready = 1'b1;
    test_reset();
    test_basic();
    test_hist_backpressure();
    test_payload_backpressure();
    test_truncation();
    test_reset_mid_drain();
`ifdef HIST_PAD_CHECK_EN
    test_pad_check();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/packet_history_extractor.md
Name: packet_history_extractor

Overview:
- Receive-side counterpart of the history-prepending stage. Strips the four 512-bit history beats that precede every packet on the AXI-Stream and emits their 16 tuples, one per handshake, on a side stream.
- Forwards the original packet beats unchanged.
- Sits downstream of the history stage, ahead of the host DMA or capture logic that consumes the flow history.

Parameters:
- C_M_AXIS_DATA_WIDTH, 512, packet stream data width. Only 512 is supported.
- C_S_AXIS_DATA_WIDTH, 512, must equal C_M_AXIS_DATA_WIDTH.
- C_M_AXIS_TUSER_WIDTH, 128, tuser width, passed through.
- C_S_AXIS_TUSER_WIDTH, 128, must equal C_M_AXIS_TUSER_WIDTH.
- TUPLE_WIDTH, 112, history tuple width: src_ip 32, dst_ip 32, src_port 16, dst_port 16, len 16.
- CNT_WIDTH, 16, width of the status counters.

Ports:
- axis_aclk in 1: single clock.
- axis_reset in 1: reset, asynchronous, active-high.
- s_axis_tdata in 512; s_axis_tkeep in 64; s_axis_tuser in 128; s_axis_tvalid in 1; s_axis_tready out 1; s_axis_tlast in 1: input stream, 4 history beats followed by the packet.
- m_axis_tdata out 512; m_axis_tkeep out 64; m_axis_tuser out 128; m_axis_tvalid out 1; m_axis_tready in 1; m_axis_tlast out 1: stripped packet stream.
- m_hist_tdata out 112: one history tuple.
- m_hist_slot out 4: slot index 0..15 of that tuple.
- m_hist_head out 4: write pointer captured from header beat 0.
- m_hist_tlast out 1: high on slot 15.
- m_hist_tvalid out 1; m_hist_tready in 1: history side-stream handshake.
- trunc_count out CNT_WIDTH: packets whose tlast arrived inside the header.

Behaviour:
- Header beat layout:
  - Beat k (k=0..3) carries slot 4k at tdata[511:400], 4k+1 at [399:288], 4k+2 at [287:176], 4k+3 at [175:64].
  - Beat 0: [63:60]=head pointer, [59:0]=pad.
  - Beats 1..3: [63:0]=pad.
  - Header tkeep and tuser are ignored and never forwarded.
- States: HDR, DRAIN, PAYLOAD. A 2-bit beat counter bcnt and a 2-bit drain counter dcnt.
- HDR:
  - s_axis_tready=1, m_axis_tvalid=0.
  - On accept with tlast=0: latch the 4 tuples into staging registers; on bcnt=0 also latch the head. Go to DRAIN with dcnt=0.
  - On accept with tlast=1: trunc_count+1 (saturating), bcnt:=0, stay in HDR, emit no tuples from this beat.
- DRAIN:
  - s_axis_tready=0.
  - m_hist_tvalid=1, m_hist_tdata=staging[dcnt], m_hist_slot={bcnt,dcnt}, m_hist_tlast=(bcnt==3 && dcnt==3).
  - On m_hist handshake, dcnt+1. After dcnt=3 handshakes:
    - bcnt<3: bcnt+1, go to HDR.
    - bcnt=3: bcnt:=0, go to PAYLOAD.
  - m_hist outputs are registered and stable while tvalid is high and tready is low.
- PAYLOAD:
  - Zero-latency pass-through: m_axis_*=s_axis_*, s_axis_tready=m_axis_tready.
  - On a handshake with tlast=1, go to HDR.
  - tkeep and tuser are bit-exact.
- Timing:
  - Header throughput with m_hist_tready held high: 5 cycles per header beat (1 accept + 4 drain), 20 cycles per packet.
  - First payload beat can transfer in the cycle after the slot-15 handshake.
- m_hist_head holds its value from the beat-0 accept until the next beat-0 accept.
- Reset (asynchronous, any state, mid-packet included): state=HDR, bcnt=dcnt=0, all counters 0, staging and m_hist_tdata/slot/head 0, every valid and tlast output 0. A packet cut by reset is not resumed; the next accepted beat is treated as header beat 0.
- Counters saturate at all-ones.

Optional Feature:
- Macro HIST_PAD_CHECK_EN.
- Defined:
  - Adds output pad_err_count (CNT_WIDTH).
  - On every accepted header beat, a nonzero pad field ([59:0] on beat 0, [63:0] on beats 1..3) increments pad_err_count, saturating.
  - Tuples are still emitted.
- Undefined: port absent, pad bits ignored, no extra logic.

Test Plan:
- Header with slots i = 112'h(i+1) repeated, head=4'h9, then a 3-beat packet, both readies high -> 16 m_hist words, slots 0..15, data 1..16, head=9, tlast only on slot 15; 3 payload beats identical to input; total 20+3 cycles.
- m_hist_tready low for 10 cycles during DRAIN of beat 1 -> m_hist_tdata/slot frozen at slot 4; s_axis_tready=0 throughout; no tuple lost or duplicated.
- m_axis_tready toggling 1/0 during a 5-beat payload -> output matches input beat-for-beat, including tkeep=64'h0000_00FF_FFFF_FFFF on the last beat.
- tlast asserted on header beat 2 -> slots 0..7 emitted, slots 8..11 not emitted, trunc_count=1; next stream treated as a fresh beat 0.
- axis_reset pulsed during DRAIN of beat 3 -> all valids 0 immediately; a following complete packet extracts correctly.
- HIST_PAD_CHECK_EN defined, beat 0 pad=60'h1 and beat 2 pad=64'h8000_0000_0000_0000 -> pad_err_count=2, all 16 tuples still emitted.
